pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline (pc, if_id, id_exe, exe_mem, mem_wb). It merges per-stage stall requests into the shared 6-bit stall vector and sequences exception flushes with a PC redirect. It also provides a debug halt/single-step mode and a stall-cycle performance counter. It sits beside top and drives the stall input that every pipeline register already consumes.

---
 rtl/pipeline_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 46 ++++
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared constants, state encoding and the stall-request
//               priority encoder used by the pipeline stall/flush sequencer.
//               Stall vector bit map: bit0 PC, bit1 IF/ID, bit2 ID/EXE,
//               bit3 EXE/MEM, bit4 MEM/WB, bit5 WB.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EXE  = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    PCTRL_RUN   = 2'd0,
    PCTRL_FLUSH = 2'd1,
    PCTRL_HALT  = 2'd2,
    PCTRL_STEP  = 2'd3
  } pctrl_state_e;

  // The deepest requesting stage wins: stalling a stage must also freeze
  // everything upstream of it, so the later stage's mask is a superset.
  function automatic logic [5:0] stall_encode(input logic req_if,
                                              input logic req_id,
                                              input logic req_exe,
                                              input logic req_mem);
    logic [5:0] enc;
    enc = STALL_NONE;
    if (req_mem)      enc = STALL_MEM;
    else if (req_exe) enc = STALL_EXE;
    else if (req_id)  enc = STALL_ID;
    else if (req_if)  enc = STALL_IF;
    return enc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones. Synchronous clear has
//               priority over increment.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low reset
//               clr   - synchronous clear
//               inc   - increment enable
//               q     - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline. Merges the
//               per-stage stall requests into the shared stall vector,
//               sequences exception flushes with a PC redirect, provides a
//               debug halt / single-step mode and counts stall cycles.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous, active-low reset
//               stallreq_if  - fetch not ready
//               stallreq_id  - load-use hazard
//               stallreq_exe - multi-cycle EXE op busy
//               stallreq_mem - data access outstanding
//               excp_req     - exception pending (held until flush seen)
//               excp_pc      - handler address
//               debug_halt   - freeze request (level)
//               debug_step   - single-step pulse while halted
//               clr_cnt      - synchronous clear of stall_cycles
//               stall        - per-stage stall vector (combinational)
//               flush        - clear all pipeline registers
//               new_pc       - redirect target while flush=1
//               halted       - 1 while halted
//               stall_cycles - request-caused stall cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_exe,
  input  logic             stallreq_mem,
  input  logic             excp_req,
  input  logic [31:0]      excp_pc,
  input  logic             debug_halt,
  input  logic             debug_step,
  input  logic             clr_cnt,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  // Flush counter counts down to zero, so it is loaded with length-1.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  pctrl_state_e state_q, state_d;
  logic         flush_q, flush_d;
  logic [31:0]  new_pc_q, new_pc_d;
  logic         halted_q, halted_d;
  logic [1:0]   fcnt_q, fcnt_d;

  logic [5:0]   w_req_stall;
  logic [5:0]   w_stall;
  logic         w_take_excp;
  logic         w_count;

  assign w_req_stall = stall_encode(stallreq_if, stallreq_id,
                                    stallreq_exe, stallreq_mem);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    new_pc_d    = new_pc_q;
    w_stall     = w_req_stall;
    w_take_excp = 1'b0;

    case (state_q)
      PCTRL_RUN, PCTRL_STEP: begin
        if (excp_req && !stallreq_mem) begin
          // Freeze every stage for the one cycle in which the redirect is
          // latched, so nothing retires past the faulting instruction.
          w_take_excp = 1'b1;
          w_stall     = STALL_ALL;
          new_pc_d    = excp_pc;
          fcnt_d      = FLUSH_LOAD;
          state_d     = PCTRL_FLUSH;
        end else if (excp_req) begin
          // An outstanding data access cannot be abandoned; hold the
          // exception until memory is done. The encoder already yields
          // the MEM mask here.
          state_d = state_q;
        end else if (state_q == PCTRL_RUN) begin
          if (debug_halt && (w_req_stall == STALL_NONE)) begin
            state_d = PCTRL_HALT;
          end
        end else if (w_req_stall == STALL_NONE) begin
          // The single step is the first unstalled cycle; it advances now.
          state_d = debug_halt ? PCTRL_HALT : PCTRL_RUN;
        end
      end

      PCTRL_FLUSH: begin
        w_stall = STALL_NONE;
        if (fcnt_q == 2'd0) begin
          state_d = debug_halt ? PCTRL_HALT : PCTRL_RUN;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end

      PCTRL_HALT: begin
        w_stall = STALL_ALL;
        if (!debug_halt) begin
          state_d = PCTRL_RUN;
        end else if (debug_step) begin
          state_d = PCTRL_STEP;
        end
      end

      default: begin
        state_d = PCTRL_RUN;
      end
    endcase
  end

  // flush and halted are registered images of the next state, so they line
  // up exactly with the cycles spent in FLUSH and HALT.
  assign flush_d  = (state_d == PCTRL_FLUSH);
  assign halted_d = (state_d == PCTRL_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PCTRL_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
      halted_q <= 1'b0;
      fcnt_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      halted_q <= halted_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Only request-caused stalls are counted; the exception freeze is not.
  assign w_count = ((state_q == PCTRL_RUN) || (state_q == PCTRL_STEP)) &&
                   (w_req_stall != STALL_NONE) && !w_take_excp;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (w_count),
    .q     (stall_cycles)
  );

  // The stall vector is combinational, so hold it quiet during reset too.
  assign stall  = reset ? w_stall : STALL_NONE;
  assign flush  = flush_q;
  assign new_pc = new_pc_q;
  assign halted = halted_q;

endmodule
`default_nettype wire
